// File: rtl/link_pkg.sv
// Types shared by the link transmit path: the 24-bit link word and the
// transmit arbiter's state encoding.
package link_pkg;

    localparam int LINK_DATA_W = 24;

    typedef struct packed {
        logic [15:0] payload;
        logic [7:0]  cmd;
    } link_word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_LOW = 2'd2
    } tx_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request after last_grant,
// wrapping around. The pointer itself is owned by the instantiating block.
module rr_arbiter
    import link_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any_req
);

    logic [IDW-1:0] idx_s;
    logic           hit_s;

    // Walk the requesters starting just after last_grant; the first one seen wins.
    always_comb begin
        grant     = {N{1'b0}};
        grant_idx = {IDW{1'b0}};
        any_req   = 1'b0;
        idx_s     = {IDW{1'b0}};
        hit_s     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s            = IDW'((int'(last_grant) + k) % N);
            hit_s            = req[idx_s] & ~any_req;
            grant[idx_s]     = grant[idx_s] | hit_s;
            grant_idx        = hit_s ? idx_s : grant_idx;
            any_req          = any_req | req[idx_s];
        end
    end

endmodule

// File: rtl/link_tx_arbiter.sv
// Shares the link transmit port between N_REQ requesters: round-robin grant,
// holds the word until the link consumes it, aborts on timeout or cable loss.
module link_tx_arbiter
    import link_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDW            = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   cable_connected,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*24-1:0]    req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [23:0]            transmit_data,
    output logic                   transmit_data_valid,
    input  logic                   transmit_data_consumed,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_drop
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_arb_state_t    state_q, state_d;
    link_word_t       data_q, data_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_drop_q, err_drop_d;
    logic             consumed_q;

    logic [N_REQ-1:0] pick_oh_s;
    logic [IDW-1:0]   pick_idx_s;
    logic             pick_any_s;
    logic             grant_now_s;
    logic             consumed_rise_s;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_oh_s),
        .grant_idx  (pick_idx_s),
        .any_req    (pick_any_s)
    );

    // The accept is suppressed while reset is asserted, since nothing would be latched.
    assign grant_now_s     = res_n && (state_q == IDLE) && cable_connected && pick_any_s;
    assign req_ready       = grant_now_s ? pick_oh_s : {N_REQ{1'b0}};
    assign consumed_rise_s = transmit_data_consumed & ~consumed_q;

    // Next-state logic; in SEND a consumption edge beats cable loss, which beats timeout.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        valid_d       = valid_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;
        err_drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_now_s) begin
                    data_d       = link_word_t'(req_data[pick_idx_s * LINK_DATA_W +: LINK_DATA_W]);
                    grant_id_d   = pick_idx_s;
                    last_grant_d = pick_idx_s;
                    cnt_d        = {CNT_W{1'b0}};
                    valid_d      = 1'b1;
                    state_d      = SEND;
                end else begin
                    valid_d      = 1'b0;
                end
            end
            SEND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (consumed_rise_s) begin
                    valid_d       = 1'b0;
                    state_d       = WAIT_LOW;
                end else if (!cable_connected) begin
                    valid_d       = 1'b0;
                    err_drop_d    = 1'b1;
                    state_d       = WAIT_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d       = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = WAIT_LOW;
                end else begin
                    valid_d       = 1'b1;
                end
            end
            WAIT_LOW: begin
                valid_d = 1'b0;
                if (!transmit_data_consumed) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q       <= IDLE;
            data_q        <= link_word_t'(24'h000000);
            valid_q       <= 1'b0;
            grant_id_q    <= {IDW{1'b0}};
            last_grant_q  <= IDW'(N_REQ - 1);
            cnt_q         <= {CNT_W{1'b0}};
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_drop_q    <= 1'b0;
            consumed_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            err_drop_q    <= err_drop_d;
            consumed_q    <= transmit_data_consumed;
        end
    end

    assign transmit_data       = data_q;
    assign transmit_data_valid = valid_q;
    assign grant_id            = grant_id_q;
    assign busy                = busy_q;
    assign err_timeout         = err_timeout_q;
    assign err_drop            = err_drop_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Scenario-per-task bench for link_tx_arbiter with a transaction-level
// round-robin model and randomized request/consume traffic.
module tb_link_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          res_n;
    logic          cable_connected;
    logic [N-1:0]  req_valid;
    logic [N*24-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [23:0]   transmit_data;
    logic          transmit_data_valid;
    logic          transmit_data_consumed;
    logic [1:0]    grant_id;
    logic          busy;
    logic          err_timeout;
    logic          err_drop;

    int n_run  = 0;
    int n_fail = 0;
    int model_last;
    logic [23:0] word_v [N];

    link_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk                    (clk),
        .res_n                  (res_n),
        .cable_connected        (cable_connected),
        .req_valid              (req_valid),
        .req_data               (req_data),
        .req_ready              (req_ready),
        .transmit_data          (transmit_data),
        .transmit_data_valid    (transmit_data_valid),
        .transmit_data_consumed (transmit_data_consumed),
        .grant_id               (grant_id),
        .busy                   (busy),
        .err_timeout            (err_timeout),
        .err_drop               (err_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int rr_next(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs(input logic [N-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < N; i++) req_data[24*i +: 24] = word_v[i];
    endtask

    task automatic do_reset;
        res_n = 1'b0;
        cable_connected = 1'b1;
        req_valid = 4'b0000;
        req_data = '0;
        transmit_data_consumed = 1'b0;
        tick;
        tick;
        res_n = 1'b1;
        model_last = N - 1;
        #1;
    endtask

    // Link consumes the word held in SEND, keeping the consumed level for hold cycles.
    task automatic consume(input int hold);
        transmit_data_consumed = 1'b1;
        tick;
        n_run++;
        if ({transmit_data_valid, busy, err_timeout, err_drop} !== 4'b0100) begin
            n_fail++;
            $display("FAIL consume_drop: got valid/busy/to/drop=%b want 0100",
                     {transmit_data_valid, busy, err_timeout, err_drop});
        end
        for (int h = 1; h < hold; h++) begin
            tick;
            n_run++;
            if ({transmit_data_valid, busy, req_ready} !== {1'b0, 1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL wait_low: got valid=%b busy=%b ready=%b want 0 1 0000",
                         transmit_data_valid, busy, req_ready);
            end
        end
        transmit_data_consumed = 1'b0;
        tick;
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_run++;
        if ({transmit_data_valid, transmit_data, req_ready, grant_id, busy, err_timeout, err_drop} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h ready=%b gid=%0d busy=%b to=%b drop=%b want all 0",
                     transmit_data_valid, transmit_data, req_ready, grant_id, busy, err_timeout, err_drop);
        end
    endtask

    task automatic test_single;
        word_v[0] = 24'h000100;
        drive_reqs(4'b0001);
        #1;
        n_run++;
        if ({req_ready, transmit_data_valid} !== 5'b0001_0) begin
            n_fail++;
            $display("FAIL single_ready: got ready=%b valid=%b want 0001 0", req_ready, transmit_data_valid);
        end
        tick;
        drive_reqs(4'b0000);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_run++;
            if ({transmit_data_valid, transmit_data, grant_id, busy, req_ready} !== {1'b1, 24'h000100, 2'd0, 1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL single_send: got valid=%b data=%h gid=%0d busy=%b ready=%b want 1 000100 0 1 0000",
                         transmit_data_valid, transmit_data, grant_id, busy, req_ready);
            end
            if (c < 2) tick;
        end
        model_last = 0;
        consume(1);
    endtask

    task automatic test_fairness;
        int served [N];
        int w;
        do_reset;
        for (int i = 0; i < N; i++) begin
            word_v[i] = 24'h000A00 | 24'(i);
            served[i] = 0;
        end
        drive_reqs(4'b1111);
        for (int n = 0; n < 8; n++) begin
            #1;
            w = rr_next(4'b1111, model_last);
            n_run++;
            if (req_ready !== 4'(1 << w)) begin
                n_fail++;
                $display("FAIL fair_ready[%0d]: got %b want %b", n, req_ready, 4'(1 << w));
            end
            tick;
            n_run++;
            if ({transmit_data_valid, grant_id, transmit_data} !== {1'b1, 2'(w), word_v[w]}) begin
                n_fail++;
                $display("FAIL fair_word[%0d]: got valid=%b gid=%0d data=%h want 1 %0d %h",
                         n, transmit_data_valid, grant_id, transmit_data, w, word_v[w]);
            end
            served[grant_id]++;
            model_last = w;
            consume(1);
        end
        for (int i = 0; i < N; i++) begin
            n_run++;
            if (served[i] !== 2) begin
                n_fail++;
                $display("FAIL fair_count[%0d]: got %0d want 2", i, served[i]);
            end
        end
        drive_reqs(4'b0000);
    endtask

    task automatic test_consumed_held;
        int w;
        word_v[1] = 24'h123456;
        word_v[2] = 24'hABCDEF;
        drive_reqs(4'b0110);
        #1;
        w = rr_next(4'b0110, model_last);
        tick;
        drive_reqs(4'b0110 & ~4'(1 << w));
        model_last = w;
        consume(5);
        #1;
        w = rr_next(4'b0110 & ~4'(1 << model_last), model_last);
        n_run++;
        if (req_ready !== 4'(1 << w)) begin
            n_fail++;
            $display("FAIL held_next_ready: got %b want %b", req_ready, 4'(1 << w));
        end
        tick;
        drive_reqs(4'b0000);
        n_run++;
        if ({transmit_data_valid, transmit_data} !== {1'b1, word_v[w]}) begin
            n_fail++;
            $display("FAIL held_next_word: got valid=%b data=%h want 1 %h", transmit_data_valid, transmit_data, word_v[w]);
        end
        model_last = w;
        consume(1);
    endtask

    task automatic test_timeout;
        do_reset;
        word_v[0] = 24'h0F0F01;
        word_v[1] = 24'h0F0F02;
        drive_reqs(4'b0011);
        #1;
        tick;
        drive_reqs(4'b0010);
        #1;
        for (int k = 0; k < TO; k++) begin
            n_run++;
            if ({transmit_data_valid, err_timeout} !== 2'b10) begin
                n_fail++;
                $display("FAIL timeout_hold[%0d]: got valid=%b to=%b want 1 0", k, transmit_data_valid, err_timeout);
            end
            tick;
        end
        n_run++;
        if ({transmit_data_valid, err_timeout, err_drop} !== 3'b010) begin
            n_fail++;
            $display("FAIL timeout_abort: got valid=%b to=%b drop=%b want 0 1 0", transmit_data_valid, err_timeout, err_drop);
        end
        tick;
        n_run++;
        if ({err_timeout, busy, req_ready} !== {1'b0, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL timeout_after: got to=%b busy=%b ready=%b want 0 0 0010", err_timeout, busy, req_ready);
        end
        tick;
        drive_reqs(4'b0000);
        n_run++;
        if ({transmit_data_valid, grant_id, transmit_data} !== {1'b1, 2'd1, 24'h0F0F02}) begin
            n_fail++;
            $display("FAIL timeout_next: got valid=%b gid=%0d data=%h want 1 1 0f0f02", transmit_data_valid, grant_id, transmit_data);
        end
        model_last = 1;
        consume(1);
    endtask

    task automatic test_cable_drop;
        word_v[2] = 24'h220002;
        word_v[3] = 24'h330003;
        drive_reqs(4'b1100);
        #1;
        tick;
        drive_reqs(4'b1000);
        tick;
        tick;
        tick;
        cable_connected = 1'b0;
        tick;
        n_run++;
        if ({transmit_data_valid, err_drop, err_timeout} !== 3'b010) begin
            n_fail++;
            $display("FAIL drop_abort: got valid=%b drop=%b to=%b want 0 1 0", transmit_data_valid, err_drop, err_timeout);
        end
        for (int c = 0; c < 4; c++) begin
            tick;
            n_run++;
            if ({err_drop, busy, transmit_data_valid, req_ready} !== 7'b0) begin
                n_fail++;
                $display("FAIL drop_idle[%0d]: got drop=%b busy=%b valid=%b ready=%b want 0 0 0 0000",
                         c, err_drop, busy, transmit_data_valid, req_ready);
            end
        end
        cable_connected = 1'b1;
        #1;
        n_run++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL drop_resume_ready: got %b want 1000", req_ready);
        end
        tick;
        drive_reqs(4'b0000);
        n_run++;
        if ({transmit_data_valid, grant_id, transmit_data} !== {1'b1, 2'd3, 24'h330003}) begin
            n_fail++;
            $display("FAIL drop_resume_word: got valid=%b gid=%0d data=%h want 1 3 330003", transmit_data_valid, grant_id, transmit_data);
        end
        model_last = 3;
        consume(1);
        // Consumption and cable loss in the same cycle is a success.
        word_v[0] = 24'h440004;
        drive_reqs(4'b0001);
        #1;
        tick;
        drive_reqs(4'b0000);
        transmit_data_consumed = 1'b1;
        cable_connected = 1'b0;
        tick;
        n_run++;
        if ({transmit_data_valid, err_drop, err_timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL consume_beats_drop: got valid=%b drop=%b to=%b want 0 0 0", transmit_data_valid, err_drop, err_timeout);
        end
        transmit_data_consumed = 1'b0;
        cable_connected = 1'b1;
        tick;
        model_last = 0;
    endtask

    task automatic test_mid_reset;
        word_v[1] = 24'h550005;
        drive_reqs(4'b0010);
        #1;
        tick;
        drive_reqs(4'b1111);
        res_n = 1'b0;
        #1;
        n_run++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_no_ready: got %b want 0000", req_ready);
        end
        tick;
        n_run++;
        if ({transmit_data_valid, busy, transmit_data, grant_id, err_drop, err_timeout} !== 30'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b busy=%b data=%h gid=%0d drop=%b to=%b want all 0",
                     transmit_data_valid, busy, transmit_data, grant_id, err_drop, err_timeout);
        end
        res_n = 1'b1;
        model_last = N - 1;
        #1;
        n_run++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_first_grant: got %b want 0001", req_ready);
        end
        tick;
        drive_reqs(4'b0000);
        model_last = 0;
        consume(1);
    endtask

    task automatic test_random;
        logic [N-1:0] pend;
        int w;
        int d;
        do_reset;
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    word_v[i] = 24'($urandom());
                end else if (pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (pend == '0) begin
                pend[it % N] = 1'b1;
                word_v[it % N] = 24'($urandom());
            end
            drive_reqs(pend);
            #1;
            w = rr_next(pend, model_last);
            n_run++;
            if (req_ready !== 4'(1 << w)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b (pend %b)", it, req_ready, 4'(1 << w), pend);
            end
            tick;
            pend[w] = 1'b0;
            drive_reqs(pend);
            d = $urandom_range(0, 3);
            for (int j = 0; j <= d; j++) begin
                n_run++;
                if ({transmit_data_valid, grant_id, transmit_data} !== {1'b1, 2'(w), word_v[w]}) begin
                    n_fail++;
                    $display("FAIL rand_word[%0d]: got valid=%b gid=%0d data=%h want 1 %0d %h",
                             it, transmit_data_valid, grant_id, transmit_data, w, word_v[w]);
                end
                if (j < d) tick;
            end
            model_last = w;
            consume($urandom_range(1, 3));
        end
        drive_reqs('0);
    endtask

    initial begin
        res_n = 1'b0;
        cable_connected = 1'b1;
        req_valid = '0;
        req_data = '0;
        transmit_data_consumed = 1'b0;
        for (int i = 0; i < N; i++) word_v[i] = 24'h000000;
        test_reset;
        test_single;
        test_fairness;
        test_consumed_held;
        test_timeout;
        test_cable_drop;
        test_mid_reset;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
